// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected psum drain block.
package fc_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

    localparam int DATA_W = 8;

    // Clamp an unsigned accumulator value to the 8-bit output range.
    function automatic logic [DATA_W-1:0] sat8(input logic [31:0] acc);
        return (acc > 32'd255) ? 8'hFF : acc[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/fc_acc_bank.sv
// NUM_OUT x ACC_W accumulator register file: clear-all, add-at-index, async read.
module fc_acc_bank
    import fc_pkg::*;
#(
    parameter int NUM_OUT = 16,
    parameter int ACC_W   = 16,
    parameter int IDX_W   = $clog2(NUM_OUT)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              add_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] add_val,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [ACC_W-1:0]  rd_data
);

    logic [NUM_OUT-1:0][ACC_W-1:0] acc;

    // No reset: every pass clears the bank when it starts.
    always_ff @(posedge clk) begin
        if (clr)
            acc <= '0;
        else if (add_en)
            acc[wr_idx] <= acc[wr_idx] + ACC_W'(add_val);
    end

    assign rd_data = acc[rd_idx];

endmodule

// File: rtl/fc_psum_drain.sv
// Receive end of the FC psum chain: accumulates per-neuron psums over tiles,
// then drains saturated 8-bit results over a valid/ready handshake.
module fc_psum_drain
    import fc_pkg::*;
#(
    parameter int NUM_OUT = 16,
    parameter int ACC_W   = 16,
    parameter int TILE_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              psum_valid,
    input  logic [DATA_W-1:0] psum_i,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int IDX_W = $clog2(NUM_OUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

    state_e             state, state_nxt;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic [TILE_W-1:0]  tile, tiles_lat;
    logic [ACC_W-1:0]   rd_data;

    logic clr, add_en, xfer, accum_last, drain_last;

    assign accum_last = (wr_idx == LAST_IDX) && (tile == tiles_lat - 1'b1);

    always_comb begin
        state_nxt  = state;
        clr        = 1'b0;
        add_en     = 1'b0;
        xfer       = 1'b0;
        drain_last = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (psum_valid) begin
                    add_en = 1'b1;
                    if (accum_last)
                        state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    xfer = 1'b1;
                    if (rd_idx == LAST_IDX) begin
                        drain_last = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_idx    <= '0;
            rd_idx    <= '0;
            tile      <= '0;
            tiles_lat <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= drain_last;

            if (clr) begin
                tiles_lat <= (num_tiles == '0) ? TILE_W'(1) : num_tiles;
                wr_idx    <= '0;
                tile      <= '0;
                overrun   <= 1'b0;
            end else if (psum_valid && state != ACCUM) begin
                overrun <= 1'b1;
            end

            if (add_en) begin
                if (wr_idx == LAST_IDX) begin
                    wr_idx <= '0;
                    tile   <= tile + 1'b1;
                    if (accum_last)
                        rd_idx <= '0;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end

            if (drain_last)
                rd_idx <= '0;
            else if (xfer)
                rd_idx <= rd_idx + 1'b1;
        end
    end

    fc_acc_bank #(
        .NUM_OUT (NUM_OUT),
        .ACC_W   (ACC_W),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk     (clk),
        .clr     (clr),
        .add_en  (add_en),
        .wr_idx  (wr_idx),
        .add_val (psum_i),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // out_valid follows the registered state, so data is gated to 0 outside DRAIN.
    assign out_valid = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign out_data  = out_valid ? sat8(32'(rd_data)) : '0;

endmodule

// File: tb/tb_fc_psum_drain.sv
// Directed + randomized bench for fc_psum_drain against a per-neuron sum model.
module tb_fc_psum_drain;

    localparam int NUM_OUT = 16;
    localparam int ACC_W   = 16;
    localparam int TILE_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [TILE_W-1:0] num_tiles = '0;
    logic              psum_valid = 1'b0;
    logic [7:0]        psum_i = '0;
    logic              out_ready = 1'b0;
    logic              out_valid, busy, done, overrun;
    logic [7:0]        out_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fc_psum_drain #(
        .NUM_OUT (NUM_OUT),
        .ACC_W   (ACC_W),
        .TILE_W  (TILE_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_tiles  (num_tiles),
        .psum_valid (psum_valid),
        .psum_i     (psum_i),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // fixval >= 0: constant sample; -1: random; -2: ramp (sample index).
    // rmode 0: ready always high; 1: 1,0,0,1 pattern; 2: random.
    task automatic run_pass(input int tiles, input int gap_pct, input int rmode,
                            input int fixval, input bit start_mid, input bit psum_in_drain);
        int ntl, n, k, cyc, v;
        int acc[NUM_OUT];
        int exp_v[NUM_OUT];
        int samples[$];
        bit r;
        ntl = (tiles == 0) ? 1 : tiles;
        n   = NUM_OUT * ntl;
        for (int i = 0; i < NUM_OUT; i++) acc[i] = 0;
        for (int s = 0; s < n; s++) begin
            if (fixval >= 0)       v = fixval;
            else if (fixval == -2) v = s & 255;
            else                   v = $urandom_range(0, 255);
            samples.push_back(v);
            acc[s % NUM_OUT] = (acc[s % NUM_OUT] + v) % (1 << ACC_W);
        end
        for (int i = 0; i < NUM_OUT; i++) exp_v[i] = (acc[i] > 255) ? 255 : acc[i];

        start = 1'b1;
        num_tiles = TILE_W'(tiles);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("done_one_cycle", 32'(done), 0);
        chk("overrun_cleared_by_start", 32'(overrun), 0);

        for (int s = 0; s < n; s++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                psum_valid = 1'b0;
                @(negedge clk);
            end
            if (s == n - 1) chk("no_valid_during_accum", 32'(out_valid), 0);
            psum_valid = 1'b1;
            psum_i = 8'(samples[s]);
            start = start_mid && (s == n / 2);
            @(negedge clk);
        end
        psum_valid = 1'b0;
        start = 1'b0;
        chk("first_valid_latency", 32'(out_valid), 1);

        k = 0;
        cyc = 0;
        while (k < NUM_OUT && cyc < 2000) begin
            chk("drain_valid", 32'(out_valid), 1);
            chk($sformatf("drain_data[%0d]", k), 32'(out_data), 32'(exp_v[k]));
            chk("no_early_done", 32'(done), 0);
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            psum_valid = psum_in_drain ? ((cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
            psum_i = 8'($urandom);
            if (r) k++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        psum_valid = 1'b0;
        chk("drain_count", 32'(k), NUM_OUT);
        if (rmode == 0) chk("drain_cycles_back_to_back", 32'(cyc), NUM_OUT);
        chk("done_pulse", 32'(done), 1);
        chk("valid_low_after_drain", 32'(out_valid), 0);
        chk("busy_low_after_drain", 32'(busy), 0);
        if (psum_in_drain) chk("overrun_from_drain", 32'(overrun), 1);
    endtask

    initial begin
        // reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_out_data", 32'(out_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single tile ramp, then back-to-back passes started in the done cycle
        run_pass(1, 0, 0, -2, 1'b0, 1'b0);
        run_pass(3, 0, 0, 100, 1'b0, 1'b0);
        run_pass(3, 0, 0, 50, 1'b0, 1'b0);
        // backpressure
        run_pass(1, 0, 1, -1, 1'b0, 1'b0);
        @(negedge clk);
        chk("done_drops", 32'(done), 0);

        // psum in IDLE sets overrun; gaps, random ready and psum during drain
        psum_valid = 1'b1;
        psum_i = 8'd200;
        @(negedge clk);
        psum_valid = 1'b0;
        chk("overrun_from_idle", 32'(overrun), 1);
        chk("idle_psum_no_busy", 32'(busy), 0);
        run_pass(2, 30, 2, -1, 1'b0, 1'b1);

        // num_tiles = 0 acts as one tile
        run_pass(0, 0, 0, -1, 1'b0, 1'b0);
        // start during ACCUM ignored
        run_pass(2, 10, 0, -1, 1'b1, 1'b0);

        // reset on the 8th sample of a pass
        start = 1'b1;
        num_tiles = 8'd2;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < 7; s++) begin
            psum_valid = 1'b1;
            psum_i = 8'd255;
            @(negedge clk);
        end
        psum_valid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        psum_valid = 1'b0;
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_overrun", 32'(overrun), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 0);
            chk("midrst_stays_idle", 32'(out_valid), 0);
        end
        run_pass(1, 20, 0, -1, 1'b0, 1'b0);
        run_pass(2, 0, 2, -1, 1'b0, 1'b0);
        @(negedge clk);
        chk("final_done_low", 32'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_psum_drain.md
Name: fc_psum_drain

Overview:
- Sits at the bottom of a fully-connected PE column and collects the 8-bit partial sums that leave the last PE.
- Accumulates them per output neuron across several input-dimension tiles, then streams saturated 8-bit results downstream over a valid/ready handshake.
- It is the receive end of the psum chain: PEs transmit, this block receives, reduces and drains.

Parameters:
- NUM_OUT, 16, number of output neurons per pass (accumulator entries); ≥2.
- ACC_W, 16, accumulator width in bits; ≥9.
- TILE_W, 8, width of the tile-count input.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset: synchronous, active-low.
- start, in, 1, begins a pass; sampled only in IDLE.
- num_tiles, in, TILE_W, tiles per pass, latched on start; 0 is treated as 1.
- psum_valid, in, 1, psum_i carries a valid partial sum this cycle.
- psum_i, in, 8, unsigned partial sum from the last PE.
- out_valid, out, 1, out_data is valid.
- out_data, out, 8, saturated result for the current neuron.
- out_ready, in, 1, downstream accepts out_data.
- busy, out, 1, high in ACCUM or DRAIN.
- done, out, 1, one-cycle pulse after the last result is accepted.
- overrun, out, 1, sticky flag: psum_valid was seen outside ACCUM; cleared by start or reset.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE.
  - out_valid, done, busy and overrun go to 0; out_data goes to 0.
  - Indices and tile count go to 0.
  - Accumulator contents are don't-care, because they are cleared on start.
  - Reset mid-pass abandons the pass immediately; no done pulse.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - start=1 latches max(num_tiles,1), clears all NUM_OUT accumulators, sets wr_idx=0, tile=0, clears overrun, then goes to ACCUM.
  - busy rises the cycle after start.
- ACCUM, on each psum_valid:
  - acc[wr_idx] <= acc[wr_idx] + zero-extended psum_i, modulo 2^ACC_W.
  - wr_idx increments. At NUM_OUT-1 it wraps to 0 and tile increments.
  - When wr_idx=NUM_OUT-1 and tile=latched_tiles-1, go to DRAIN on the same edge, with rd_idx=0.
  - Gaps in psum_valid are allowed and stall accumulation.
  - Total accepted samples per pass = NUM_OUT × tiles.
- DRAIN:
  - out_valid=1 is registered, asserted the first cycle in DRAIN.
  - out_data = (acc[rd_idx] > 255) ? 255 : acc[rd_idx][7:0].
  - Handshake: transfer occurs when out_valid & out_ready. rd_idx then increments and out_data updates next cycle.
  - out_data and out_valid hold stable while out_ready=0.
  - On transfer of rd_idx=NUM_OUT-1: go to IDLE, deassert out_valid, pulse done=1 for exactly one cycle.
- start outside IDLE is ignored.
- psum_valid in IDLE or DRAIN is dropped and sets overrun.
- Latency: first out_valid appears 1 cycle after the last psum_valid of the pass. With out_ready held high, NUM_OUT results drain in NUM_OUT consecutive cycles.
- start asserted in the same cycle as done is high (state is IDLE): accepted, and a new pass begins.

Decomposition:
- Shared package fc_pkg holds:
  - typedef state_e {IDLE, ACCUM, DRAIN};
  - localparam DATA_W=8;
  - function sat8(acc) returning the 8-bit clamp.
- Sub-module fc_acc_bank, an NUM_OUT×ACC_W register file:
  - write port: clear-all, add-at-index;
  - combinational read port at rd_idx.
- The FSM, counters and handshake live in fc_psum_drain.

Test Plan:
- Single tile (NUM_OUT=16, num_tiles=1): psum_i = 0..15 back-to-back → out_data 0..15 in order, out_valid for 16 cycles, done pulse once, busy low afterwards.
- Three tiles, psum_i=100 for all 48 samples → each acc=300 → every out_data=255 (saturation); with psum_i=50, each acc=150 → out_data=150.
- Backpressure: out_ready toggling 1,0,0,1… during DRAIN → out_data stable while stalled; all 16 values delivered exactly once in order; done only after the 16th transfer.
- Bubbles plus protocol errors:
  - psum_valid with random gaps → same results as back-to-back.
  - psum_valid=1 in IDLE → overrun=1, no accumulator change; next start clears overrun.
- num_tiles=0 → behaves as 1 tile.
- start pulsed during ACCUM → ignored, sample count unchanged.
- Reset at the 8th sample of ACCUM → IDLE, out_valid=0, done never pulses. A new start with fresh data yields correct results with no residue from the aborted pass.
